fifo_umbrales: RTL and testbench
================================

// Module: fifo_umbrales
// PURPOSE
//  Single-clock FIFO with programmable low/high occupancy thresholds; one instance per lane, eight instances
//  feed the 8-bit empty_fifos bus of the flow-control state machine. Stores lane data and reports
//  empty/full/almost_empty/almost_full plus overflow/underflow errors.
//  Thresholds arrive as the machine's bajo_out/alto_out and are latched here on init.
// PARAMETERS
//  DATA_W    6  width of one data word
//  ADDR_W    3  pointer width; DEPTH = 2**ADDR_W = 8 words
//  BAJO_RST  1  low threshold after reset
//  ALTO_RST  6  high threshold after reset
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          asynchronous, active-high
//  init          in   1          latch umbral_bajo/umbral_alto into threshold regs this cycle
//  umbral_bajo   in   ADDR_W     low threshold candidate
//  umbral_alto   in   ADDR_W     high threshold candidate
//  push          in   1          write data_in this cycle
//  data_in       in   DATA_W     write data
//  pop           in   1          read request
//  data_out      out  DATA_W     read data, registered
//  valid_out     out  1          data_out holds a word popped on the previous cycle
//  empty         out  1          count==0
//  full          out  1          count==DEPTH
//  almost_empty  out  1          count<=bajo_reg
//  almost_full   out  1          count>=alto_reg
//  count         out  ADDR_W+1   current occupancy, 0..DEPTH
//  err_overflow  out  1          sticky: push rejected while full
//  err_underflow out  1          sticky: pop rejected while empty
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0,
//    errors=0, bajo_reg=BAJO_RST, alto_reg=ALTO_RST. Outputs after reset: empty=1, full=0,
//    almost_empty=1, almost_full=0. Memory contents not cleared.
//  - Write: push && (!full || pop) -> mem[wr_ptr]<=data_in, wr_ptr+1 mod DEPTH (natural wrap).
//  - Read: pop && !empty -> data_out<=mem[rd_ptr] next edge, valid_out=1 for one cycle, rd_ptr+1 mod DEPTH.
//    Latency pop->data_out = 1 cycle. No pop or rejected pop -> valid_out=0, data_out holds last value.
//  - Count: +1 on accepted push only, -1 on accepted pop only, unchanged when both accepted.
//  - Simultaneous push+pop:
//    - full: both accepted, count stays DEPTH, no overflow.
//    - empty: push accepted, pop rejected (no bypass), err_underflow set, count->1.
//  - push while full without pop: word dropped, pointers unchanged, err_overflow<=1 (sticky until reset).
//  - pop while empty: ignored, valid_out=0, err_underflow<=1 (sticky until reset).
//  - Flags combinational from registered count and threshold regs; they reflect a push/pop the cycle after.
//  - init: bajo_reg<=umbral_bajo, alto_reg<=umbral_alto on the edge; new compare from next cycle.
//    Data path unaffected by init.
//  - Thresholds are unsigned ADDR_W bits; compare zero-extended against count. alto_reg=0 forces
//    almost_full=1. bajo_reg>=alto_reg is legal; both flags then may assert together. No checking.
// STRUCTURE
//  - Shared include (defines file): DATA_W, ADDR_W, BAJO_RST, ALTO_RST defaults, also used by the
//    state machine and lane top for consistent widths.
//  - Sub-module memoria_fifo: DEPTH x DATA_W register array, sync write port (we, waddr, wdata),
//    sync read port (re, raddr, rdata). Pointer/count/flag/error logic stays in fifo_umbrales.
// TESTING
//  1 Reset then idle: empty=1, almost_empty=1, full=0, count=0, valid_out=0, errors=0.
//  2 Push 0x01..0x08 on 8 cycles: count 8, full=1, almost_full=1 from count 6. Pop 8 cycles ->
//    data_out 0x01..0x08 each one cycle after pop, valid_out high 8 cycles, empty=1 at end.
//  3 Fill to 8, push 0x3F without pop -> dropped, err_overflow=1, count 8. Push+pop together at
//    full -> count 8, no new error. Pops return FIFO order unaffected by the drop.
//  4 Pop on empty -> valid_out=0, err_underflow=1. Push 0x15 + pop same cycle on empty -> count=1,
//    next pop returns 0x15.
//  5 init=1 with umbral_bajo=2, umbral_alto=4: push to count 2 -> almost_empty=1, count 3 ->
//    almost_empty=0, count 4 -> almost_full=1.
//  6 Wrap: 20 interleaved push/pop of incrementing data across pointer wrap -> in-order output.
//    Assert reset mid-stream -> all outputs at reset values asynchronously, before next clk edge.

Source files
------------

// File: rtl/fifo_umbrales_pkg.sv
// Shared widths, reset thresholds and operation encoding for the lane FIFO,
// its flow-control state machine and the lane top.
// Any block that sizes a lane bus or a threshold field takes its defaults from here.
package fifo_umbrales_pkg;

  // Default lane geometry: 6-bit words, 8-deep FIFO
  localparam int DATA_W_DEF   = 6;
  localparam int ADDR_W_DEF   = 3;

  // Occupancy thresholds loaded at reset, before the state machine issues init
  localparam int BAJO_RST_DEF = 1;
  localparam int ALTO_RST_DEF = 6;

  // Accepted operation in a cycle, encoded as {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Combine the accept strobes into an operation code
  function automatic op_e op_decode(input logic push_ok, input logic pop_ok);
    return op_e'({push_ok, pop_ok});
  endfunction

endpackage

// File: rtl/fifo_umbrales_memoria_fifo.sv
// Storage array for the lane FIFO: DEPTH x DATA_W registers, one write and one read port.
// Latency: write lands on the edge, read data appears one edge after re.
// Backpressure: none here; the caller only strobes we/re for accepted operations.
module memoria_fifo #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds the last word when no read is issued.
  // A same-cycle write to raddr returns the old word, which is the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_umbrales.sv
// Lane FIFO with programmable low/high occupancy thresholds and sticky error flags.
// Latency: pop -> data_out/valid_out one cycle; flags follow count one cycle after push/pop.
// Backpressure: push while full is dropped unless a pop frees a slot the same cycle.
module fifo_umbrales
  import fifo_umbrales_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BAJO_RST = BAJO_RST_DEF,
  parameter int ALTO_RST = ALTO_RST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W-1:0] umbral_bajo,
  input  logic [ADDR_W-1:0] umbral_alto,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] bajo_reg;
  logic [ADDR_W-1:0] alto_reg;
  logic              push_ok;
  logic              pop_ok;
  op_e               op;

  // Status flags come straight from registered count and thresholds
  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_empty = (count <= {1'b0, bajo_reg});
  assign almost_full  = (count >= {1'b0, alto_reg});

  // A pop on empty is never bypassed by a same-cycle push; a push on full
  // is accepted only when a pop drains a slot at the same edge
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  // Accepted-operation code drives the occupancy update
  always_comb begin
    op = OP_IDLE;
    op = op_decode(push_ok, pop_ok);
  end

  // Pointers wrap naturally at DEPTH; count moves only on a lone push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case (op)
        OP_PUSH: count <= count + CNT_ONE;
        OP_POP:  count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // valid_out marks the cycle in which data_out carries a freshly popped word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_ok;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        err_overflow <= 1'b1;
      end
      if (pop && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Threshold registers, reloaded from the state machine on init
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bajo_reg <= ADDR_W'(BAJO_RST);
      alto_reg <= ADDR_W'(ALTO_RST);
    end else if (init) begin
      bajo_reg <= umbral_bajo;
      alto_reg <= umbral_alto;
    end
  end

  memoria_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_umbrales.sv
// Bench for the lane FIFO: queue model plus output scoreboard, a table of
// hand-computed vectors, and short sequences for thresholds, wrap and async reset.
module tb_fifo_umbrales;

  logic       clk;
  logic       reset;
  logic       init;
  logic [2:0] umbral_bajo;
  logic [2:0] umbral_alto;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] count;
  logic       err_overflow;
  logic       err_underflow;

  fifo_umbrales dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .umbral_bajo   (umbral_bajo),
    .umbral_alto   (umbral_alto),
    .push          (push),
    .data_in       (data_in),
    .pop           (pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .empty         (empty),
    .full          (full),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [5:0] mq[$];
  logic [5:0] sb[$];
  int         m_bajo, m_alto;
  logic       m_ovf, m_unf, m_valid;

  typedef struct {
    logic       p;
    logic       q;
    logic [5:0] d;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_unf;
  } row_t;
  row_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_bajo  = 1;
    m_alto  = 6;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == 8));
    chk("almost_empty", int'(almost_empty), int'(n <= m_bajo));
    chk("almost_full", int'(almost_full), int'(n >= m_alto));
    chk("err_overflow", int'(err_overflow), int'(m_ovf));
    chk("err_underflow", int'(err_underflow), int'(m_unf));
    chk("valid_out", int'(valid_out), int'(m_valid));
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        chk("data_out", int'(data_out), int'(sb.pop_front()));
      end
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [5:0] d,
                      input logic in_init, input logic [2:0] ub, input logic [2:0] ua);
    logic m_full, m_empty, p_ok, q_ok;
    @(negedge clk);
    push = p; pop = q; data_in = d;
    init = in_init; umbral_bajo = ub; umbral_alto = ua;
    @(posedge clk);
    m_full  = (mq.size() == 8);
    m_empty = (mq.size() == 0);
    q_ok = q && !m_empty;
    p_ok = p && (!m_full || q);
    if (p && m_full && !q) m_ovf = 1'b1;
    if (q && m_empty) m_unf = 1'b1;
    if (q_ok) sb.push_back(mq.pop_front());
    if (p_ok) mq.push_back(d);
    if (in_init) begin
      m_bajo = int'(ub);
      m_alto = int'(ua);
    end
    m_valid = q_ok;
    #1;
    check_outputs();
  endtask

  task automatic add(input logic p, input logic q, input logic [5:0] d,
                     input int c, input logic o, input logic u);
    row_t r;
    r.p = p; r.q = q; r.d = d; r.exp_count = c; r.exp_ovf = o; r.exp_unf = u;
    tbl.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time=%0t limit=100000", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; init = 1'b0; umbral_bajo = '0; umbral_alto = '0;
    push = 1'b0; pop = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset then idle
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_ovf", int'(err_overflow), 0);
    chk("rst_unf", int'(err_underflow), 0);
    step(0, 0, 0, 0, 0, 0);

    // Fill with 1..8, then drain in order
    for (int i = 1; i <= 8; i++) step(1, 0, 6'(i), 0, 0, 0);
    chk("fill_count8", int'(count), 8);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_empty", int'(empty), 1);

    // Programmed thresholds low=2, high=4
    step(0, 0, 0, 1, 3'd2, 3'd4);
    step(1, 0, 6'h0A, 0, 0, 0);
    step(1, 0, 6'h0B, 0, 0, 0);
    chk("thr_ae_at2", int'(almost_empty), 1);
    step(1, 0, 6'h0C, 0, 0, 0);
    chk("thr_ae_at3", int'(almost_empty), 0);
    chk("thr_af_at3", int'(almost_full), 0);
    step(1, 0, 6'h0D, 0, 0, 0);
    chk("thr_af_at4", int'(almost_full), 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd1, 3'd6);

    // Hand-computed vectors: underflow, empty push+pop, overflow drop, full push+pop
    add(0, 1, 6'h00, 0, 0, 1);
    add(1, 1, 6'h15, 1, 0, 1);
    add(0, 1, 6'h00, 0, 0, 1);
    for (int i = 1; i <= 8; i++) add(1, 0, 6'(i), i, 0, 1);
    add(1, 0, 6'h3F, 8, 1, 1);
    add(1, 1, 6'h20, 8, 1, 1);
    for (int i = 7; i >= 0; i--) add(0, 1, 6'h00, i, 1, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].q, tbl[i].d, 0, 0, 0);
      chk("tbl_count", int'(count), tbl[i].exp_count);
      chk("tbl_ovf", int'(err_overflow), int'(tbl[i].exp_ovf));
      chk("tbl_unf", int'(err_underflow), int'(tbl[i].exp_unf));
    end
    step(0, 0, 0, 0, 0, 0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step(1, (i >= 2) && (i % 3 != 0), 6'((i + 1) & 63), 0, 0, 0);
    end
    while (mq.size() > 0) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_sb_drained", sb.size(), 0);

    // Asynchronous reset in the middle of a transfer
    step(1, 0, 6'h11, 0, 0, 0);
    step(1, 0, 6'h22, 0, 0, 0);
    step(1, 1, 6'h33, 0, 0, 0);
    chk("pre_rst_valid", int'(valid_out), 1);
    push = 1'b0; pop = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_almost_empty", int'(almost_empty), 1);
    chk("arst_almost_full", int'(almost_full), 0);
    chk("arst_valid", int'(valid_out), 0);
    chk("arst_data_out", int'(data_out), 0);
    chk("arst_ovf", int'(err_overflow), 0);
    chk("arst_unf", int'(err_underflow), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 6'h2A, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
